// File: rtl/branch_pkg.sv
// Shared constants and helpers for the branch predictor slice.
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Two-bit saturating counter step toward the observed outcome.
  function automatic logic [1:0] satUpdate(input logic [1:0] cnt, input logic taken);
    logic [1:0] nextCnt;
    nextCnt = cnt;
    if (taken) begin
      if (cnt != ST) nextCnt = cnt + 2'd1;
    end else begin
      if (cnt != SNT) nextCnt = cnt - 2'd1;
    end
    return nextCnt;
  endfunction

  // funct3 010/011 are not conditional branches.
  function automatic logic isLegalBranch(input logic [2:0] funct3);
    return (funct3 == BEQ) || (funct3 == BNE) || (funct3 == BLT) ||
           (funct3 == BGE) || (funct3 == BLTU) || (funct3 == BGEU);
  endfunction

  // Real direction from the comparator flags.
  function automatic logic branchTaken(input logic [2:0] funct3, input logic brEq,
                                       input logic brLt);
    logic taken;
    case (funct3)
      BEQ:         taken = brEq;
      BNE:         taken = !brEq;
      BLT, BLTU:   taken = brLt;
      BGE, BGEU:   taken = !brLt;
      default:     taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Table of 2-bit saturating counters: one combinational read, one clocked write.
module bht_2bit
  import branch_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX     = $clog2(ENTRIES)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [IDX-1:0] rdIdx,
  output logic [1:0]     rdCounter,
  input  logic           wrEn,
  input  logic [IDX-1:0] wrIdx,
  input  logic           wrTaken
);

  logic [1:0] cntTable [ENTRIES];

  // Counters start weakly not-taken; a resolved branch nudges its entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) cntTable[i] <= WNT;
    end else if (wrEn) begin
      cntTable[wrIdx] <= satUpdate(cntTable[wrIdx], wrTaken);
    end
  end

  // No write-to-read bypass: a same-cycle read sees the old value.
  assign rdCounter = cntTable[rdIdx];

endmodule

// File: rtl/branch_predictor.sv
// Branch direction predictor and EX-stage resolver.
// Optional statistics counters are built only when BP_STATS_EN is defined.
module branch_predictor
  import branch_pkg::*;
#(
  parameter int BHT_ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic        BrEq,
  input  logic        BrLT,
  output logic        BrUn,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int IDX = $clog2(BHT_ENTRIES);

  logic [1:0]  predCounter;
  logic        resolve;
  logic        outcome;
  logic        mispredict;
  logic [31:0] fallThrough;
  logic [31:0] correctPc;
  logic        redirectQ;
  logic [31:0] redirectPcQ;

  bht_2bit #(
    .ENTRIES(BHT_ENTRIES),
    .IDX    (IDX)
  ) uBht (
    .clk      (clk),
    .rst      (rst),
    .rdIdx    (if_pc[IDX+1:2]),
    .rdCounter(predCounter),
    .wrEn     (resolve),
    .wrIdx    (ex_pc[IDX+1:2]),
    .wrTaken  (outcome)
  );

  logic unusedBits;
  assign unusedBits = ^{if_pc[31:IDX+2], if_pc[1:0], predCounter[0]};

  assign if_pred_taken = predCounter[1];
  assign BrUn          = (ex_funct3 == BLTU) || (ex_funct3 == BGEU);

  // Wrong-path instructions behind a pending redirect never resolve.
  always_comb begin
    outcome     = branchTaken(ex_funct3, BrEq, BrLT);
    resolve     = ex_valid && ex_is_branch && isLegalBranch(ex_funct3) && !redirectQ;
    mispredict  = resolve && (outcome != ex_pred_taken);
    fallThrough = ex_pc + 32'd4;
    correctPc   = outcome ? ex_target : fallThrough;
  end

  // One-cycle redirect pulse; the target is held between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirectQ   <= 1'b0;
      redirectPcQ <= 32'd0;
    end else begin
      redirectQ <= mispredict;
      if (mispredict) redirectPcQ <= correctPc;
    end
  end

  assign redirect_valid = redirectQ;
  assign flush          = redirectQ;
  assign redirect_pc    = redirectPcQ;

`ifdef BP_STATS_EN
  logic [31:0] branchCount;
  logic [31:0] mispredictCount;

  // Saturating event counters for resolves and mispredicts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branchCount     <= 32'd0;
      mispredictCount <= 32'd0;
    end else begin
      if (resolve && (branchCount != 32'hFFFF_FFFF)) branchCount <= branchCount + 32'd1;
      if (mispredict && (mispredictCount != 32'hFFFF_FFFF))
        mispredictCount <= mispredictCount + 32'd1;
    end
  end

  assign stat_branches    = branchCount;
  assign stat_mispredicts = mispredictCount;
`else
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule
